// File: rtl/m_microseq_pkg.sv
// Shared constants for the microsequencer: branch-condition codes, FSM state
// codes, control-store address width and the decode-address builder.
package m_microseq_pkg;

    localparam int CS_ADDR_W = 11;
    localparam logic DEC_PREFIX = 1'b1;

    // COND 3'b000 (plain increment) is the default arm of the select
    localparam logic [2:0] COND_N      = 3'b001;
    localparam logic [2:0] COND_Z      = 3'b010;
    localparam logic [2:0] COND_V      = 3'b011;
    localparam logic [2:0] COND_C      = 3'b100;
    localparam logic [2:0] COND_B13    = 3'b101;
    localparam logic [2:0] COND_JUMP   = 3'b110;
    localparam logic [2:0] COND_DECODE = 3'b111;

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic logic [10:0] decode_addr(input logic [1:0] op, input logic [5:0] op3);
        return {DEC_PREFIX, op, op3, 2'b00};
    endfunction

endpackage

// File: rtl/m_microseq_if.sv
// Bundle of MIR fields, IR/PSR inputs, memory handshake and sequencer outputs.
interface m_microseq_if
    import m_microseq_pkg::*;
#(
    parameter int ADDR_W = CS_ADDR_W
);
    logic [2:0]        mir_cond;
    logic [ADDR_W-1:0] mir_jaddr;
    logic              mir_rd;
    logic              mir_wr;
    logic [1:0]        ir_op;
    logic [5:0]        ir_op3;
    logic              ir_b13;
    logic              psr_n;
    logic              psr_z;
    logic              psr_v;
    logic              psr_c;
    logic              mem_ack;
    logic [ADDR_W-1:0] cs_addr;
    logic              busy;
    logic              mem_timeout;

    modport master (
        output mir_cond, mir_jaddr, mir_rd, mir_wr, ir_op, ir_op3, ir_b13,
               psr_n, psr_z, psr_v, psr_c, mem_ack,
        input  cs_addr, busy, mem_timeout
    );

    modport slave (
        input  mir_cond, mir_jaddr, mir_rd, mir_wr, ir_op, ir_op3, ir_b13,
               psr_n, psr_z, psr_v, psr_c, mem_ack,
        output cs_addr, busy, mem_timeout
    );

endinterface

// File: rtl/m_microseq_cbl.sv
// Control branch logic: combinational next-address select driven by MIR COND.
module m_cbl
    import m_microseq_pkg::*;
#(
    parameter int ADDR_W = CS_ADDR_W
) (
    input  logic [2:0]        cond,
    input  logic [ADDR_W-1:0] jaddr,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic [1:0]        ir_op,
    input  logic [5:0]        ir_op3,
    input  logic              ir_b13,
    input  logic              psr_n,
    input  logic              psr_z,
    input  logic              psr_v,
    input  logic              psr_c,
    output logic [ADDR_W-1:0] next_addr
);

    logic taken;

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_N:    taken = psr_n;
            COND_Z:    taken = psr_z;
            COND_V:    taken = psr_v;
            COND_C:    taken = psr_c;
            COND_B13:  taken = ir_b13;
            COND_JUMP: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    always_comb begin
        if (cond == COND_DECODE)
            next_addr = ADDR_W'(decode_addr(ir_op, ir_op3));
        else if (taken)
            next_addr = jaddr;
        else
            next_addr = inc_addr;
    end

endmodule

// File: rtl/m_microseq.sv
// Microsequencer: control-store address register, memory-wait FSM with a
// bounded wait counter and sticky timeout flag.
module m_microseq
    import m_microseq_pkg::*;
#(
    parameter int ADDR_W   = CS_ADDR_W,
    parameter int WAIT_MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    m_microseq_if.slave  bus
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    // Counter is cleared on entry, so the final WAIT cycle sees WAIT_MAX-1
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] inc_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [CNT_W-1:0]  wait_cnt;
    logic              busy_q;
    logic              timeout_q;
    logic              mem_req;

    assign inc_addr = addr_q + ADDR_W'(1);
    assign mem_req  = bus.mir_rd | bus.mir_wr;

    m_cbl #(.ADDR_W(ADDR_W)) u_cbl (
        .cond      (bus.mir_cond),
        .jaddr     (bus.mir_jaddr),
        .inc_addr  (inc_addr),
        .ir_op     (bus.ir_op),
        .ir_op3    (bus.ir_op3),
        .ir_b13    (bus.ir_b13),
        .psr_n     (bus.psr_n),
        .psr_z     (bus.psr_z),
        .psr_v     (bus.psr_v),
        .psr_c     (bus.psr_c),
        .next_addr (next_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RST;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_RST: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (mem_req && !bus.mem_ack) begin
                        state    <= ST_WAIT;
                        busy_q   <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        addr_q <= next_addr;
                    end
                end
                ST_WAIT: begin
                    // mem_ack takes precedence over an expiring wait
                    if (bus.mem_ack) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                        addr_q <= next_addr;
                    end else if (wait_cnt == CNT_LAST) begin
                        state     <= ST_RUN;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        addr_q    <= next_addr;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_RST;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cs_addr     = addr_q;
    assign bus.busy        = busy_q;
    assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_m_microseq.sv
// Self-checking bench for m_microseq: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
module tb_m_microseq;

    localparam int AW   = 11;
    localparam int WMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    m_microseq_if #(.ADDR_W(AW)) bus();

    m_microseq #(.ADDR_W(AW), .WAIT_MAX(WMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_addr    = 0;
    bit m_busy    = 1'b0;
    bit m_to      = 1'b0;
    bit m_hold    = 1'b1;
    bit m_wait    = 1'b0;
    int m_waited  = 0;

    function automatic int model_next(input int a);
        int inc;
        inc = (a + 1) % 2048;
        case (bus.mir_cond)
            3'd1: return bus.psr_n  ? int'(bus.mir_jaddr) : inc;
            3'd2: return bus.psr_z  ? int'(bus.mir_jaddr) : inc;
            3'd3: return bus.psr_v  ? int'(bus.mir_jaddr) : inc;
            3'd4: return bus.psr_c  ? int'(bus.mir_jaddr) : inc;
            3'd5: return bus.ir_b13 ? int'(bus.mir_jaddr) : inc;
            3'd6: return int'(bus.mir_jaddr);
            3'd7: return 1024 + int'(bus.ir_op) * 256 + int'(bus.ir_op3) * 4;
            default: return inc;
        endcase
    endfunction

    // Advance one clock; the model consumes the same inputs the DUT sees at the edge
    task automatic tick();
        int nx;
        nx = model_next(m_addr);
        if (rst) begin
            m_addr = 0; m_to = 1'b0; m_hold = 1'b1; m_wait = 1'b0; m_waited = 0;
        end else if (m_hold) begin
            m_hold = 1'b0;
        end else if (!m_wait) begin
            if ((bus.mir_rd || bus.mir_wr) && !bus.mem_ack) begin
                m_wait = 1'b1; m_waited = 0;
            end else begin
                m_addr = nx;
            end
        end else if (bus.mem_ack) begin
            m_addr = nx; m_wait = 1'b0;
        end else begin
            m_waited++;
            if (m_waited == WMAX) begin
                m_to = 1'b1; m_addr = nx; m_wait = 1'b0;
            end
        end
        m_busy = m_wait;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.mir_cond = 3'd0; bus.mir_jaddr = '0; bus.mir_rd = 1'b0; bus.mir_wr = 1'b0;
        bus.ir_op = 2'd0; bus.ir_op3 = 6'd0; bus.ir_b13 = 1'b0;
        bus.psr_n = 1'b0; bus.psr_z = 1'b0; bus.psr_v = 1'b0; bus.psr_c = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
    endtask

    task automatic goto_addr(input logic [AW-1:0] a);
        bus.mir_rd = 1'b0; bus.mir_wr = 1'b0;
        bus.mir_cond = 3'd6; bus.mir_jaddr = a; tick();
        bus.mir_cond = 3'd0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] seq [4];
        seq = '{11'd0, 11'd1, 11'd2, 11'd3};
        set_idle();
        rst = 1'b1; tick();
        checks++; if (bus.cs_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.cs_addr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus.mem_timeout); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.cs_addr !== seq[i]) begin errors++; $display("FAIL free_run[%0d]: got %0h want %0h", i, bus.cs_addr, seq[i]); end
        end
    endtask

    task automatic test_branch();
        logic [AW-1:0] want;
        for (int c = 1; c <= 5; c++) begin
            for (int v = 0; v < 2; v++) begin
                goto_addr(11'd5);
                bus.mir_cond = 3'(c); bus.mir_jaddr = 11'h040;
                bus.psr_n = (c == 1) ? v[0] : !v[0];
                bus.psr_z = (c == 2) ? v[0] : !v[0];
                bus.psr_v = (c == 3) ? v[0] : !v[0];
                bus.psr_c = (c == 4) ? v[0] : !v[0];
                bus.ir_b13 = (c == 5) ? v[0] : !v[0];
                tick();
                want = v[0] ? 11'h040 : 11'd6;
                checks++;
                if (bus.cs_addr !== want) begin errors++; $display("FAIL branch c=%0d v=%0d: got %0h want %0h", c, v, bus.cs_addr, want); end
            end
        end
        set_idle();
    endtask

    task automatic test_decode();
        bus.mir_cond = 3'd7; bus.ir_op = 2'b10; bus.ir_op3 = 6'b010000; tick();
        checks++;
        if (bus.cs_addr !== 11'h640) begin errors++; $display("FAIL decode: got %0h want 640", bus.cs_addr); end
        bus.ir_op = 2'b01; bus.ir_op3 = 6'b111111; tick();
        checks++;
        if (bus.cs_addr !== 11'h5FC) begin errors++; $display("FAIL decode2: got %0h want 5fc", bus.cs_addr); end
        set_idle();
    endtask

    task automatic test_wait();
        goto_addr(11'd9);
        bus.mir_rd = 1'b1; bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.cs_addr !== 11'd9 || bus.busy !== 1'b1) begin
                errors++; $display("FAIL wait_hold[%0d]: got addr %0h busy %b want 9 1", i, bus.cs_addr, bus.busy);
            end
        end
        bus.mem_ack = 1'b1; tick();
        checks++;
        if (bus.cs_addr !== 11'd10 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL wait_release: got addr %0h busy %b want a 0", bus.cs_addr, bus.busy);
        end
        bus.mir_rd = 1'b0; bus.mir_wr = 1'b1; tick();
        checks++;
        if (bus.cs_addr !== 11'd11 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL immediate_ack: got addr %0h busy %b want b 0", bus.cs_addr, bus.busy);
        end
        set_idle();
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        goto_addr(11'h030);
        bus.mir_rd = 1'b1; bus.mem_ack = 1'b0;
        for (int i = 0; i < WMAX; i++) tick();
        bus.mem_ack = 1'b1; tick();
        checks++;
        if (bus.cs_addr !== 11'h031 || bus.mem_timeout !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL ack_at_limit: got addr %0h to %b busy %b want 31 0 0", bus.cs_addr, bus.mem_timeout, bus.busy);
        end
        set_idle();
    endtask

    task automatic test_timeout();
        goto_addr(11'h020);
        bus.mir_wr = 1'b1; bus.mem_ack = 1'b0;
        for (int i = 0; i < WMAX; i++) begin
            tick();
            checks++;
            if (bus.cs_addr !== 11'h020 || bus.busy !== 1'b1 || bus.mem_timeout !== 1'b0) begin
                errors++; $display("FAIL timeout_wait[%0d]: got addr %0h busy %b to %b want 20 1 0", i, bus.cs_addr, bus.busy, bus.mem_timeout);
            end
        end
        tick();
        checks++;
        if (bus.cs_addr !== 11'h021 || bus.busy !== 1'b0 || bus.mem_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_fire: got addr %0h busy %b to %b want 21 0 1", bus.cs_addr, bus.busy, bus.mem_timeout);
        end
        bus.mir_wr = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.mem_timeout !== 1'b1 || bus.cs_addr !== 11'h024) begin
            errors++; $display("FAIL timeout_sticky: got to %b addr %0h want 1 24", bus.mem_timeout, bus.cs_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        goto_addr(11'h7FF);
        bus.mir_rd = 1'b1; bus.mem_ack = 1'b0;
        tick(); tick();
        checks++;
        if (bus.cs_addr !== 11'h7FF || bus.busy !== 1'b1 || bus.mem_timeout !== 1'b1) begin
            errors++; $display("FAIL mid_wait_pre: got addr %0h busy %b to %b want 7ff 1 1", bus.cs_addr, bus.busy, bus.mem_timeout);
        end
        rst = 1'b1; tick();
        checks++;
        if (bus.cs_addr !== 11'd0 || bus.busy !== 1'b0 || bus.mem_timeout !== 1'b0) begin
            errors++; $display("FAIL mid_wait_rst: got addr %0h busy %b to %b want 0 0 0", bus.cs_addr, bus.busy, bus.mem_timeout);
        end
        rst = 1'b0; bus.mir_rd = 1'b0; tick();
        checks++;
        if (bus.cs_addr !== 11'd0) begin errors++; $display("FAIL rst_hold: got %0h want 0", bus.cs_addr); end
        goto_addr(11'h7FF);
        tick();
        checks++;
        if (bus.cs_addr !== 11'd0) begin errors++; $display("FAIL wrap: got %0h want 0", bus.cs_addr); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.mir_cond  = 3'($urandom_range(0, 7));
            bus.mir_jaddr = 11'($urandom);
            bus.mir_rd    = ($urandom_range(0, 3) == 0);
            bus.mir_wr    = ($urandom_range(0, 5) == 0);
            bus.mem_ack   = ($urandom_range(0, 3) == 0);
            bus.ir_op     = 2'($urandom);
            bus.ir_op3    = 6'($urandom);
            bus.ir_b13    = 1'($urandom);
            bus.psr_n     = 1'($urandom);
            bus.psr_z     = 1'($urandom);
            bus.psr_v     = 1'($urandom);
            bus.psr_c     = 1'($urandom);
            tick();
            checks++;
            if (bus.cs_addr !== 11'(m_addr) || bus.busy !== m_busy || bus.mem_timeout !== m_to) begin
                errors++;
                $display("FAIL random[%0d]: got addr %0h busy %b to %b want %0h %b %b",
                         i, bus.cs_addr, bus.busy, bus.mem_timeout, m_addr, m_busy, m_to);
            end
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_branch();
        test_decode();
        test_wait();
        test_ack_at_limit();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
